// File: rtl/kgp_alu_defs.sv
// -----------------------------------------------------------------------------
// kgp_alu_defs : shared definitions for the KGP-RISC execute-stage ALU blocks.
//   WIDTH      operand width of the datapath (fixed at 32, matches the adder)
//   CNT_W      width of the multiplier step counter
//   MUL_STEPS  number of shift-add steps per multiplication
//   mul_state_t  sequential multiplier FSM encoding (IDLE / RUN / DONE)
// -----------------------------------------------------------------------------
package kgp_alu_defs;

    localparam int WIDTH     = 32;
    localparam int CNT_W     = 5;
    localparam int MUL_STEPS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage : kgp_alu_defs

// File: rtl/hybrid_adder.sv
// -----------------------------------------------------------------------------
// hybrid_adder : 32-bit adder, ripple lower half plus carry-select upper half.
// Ports:
//   a, b  [31:0]  addends
//   cin           carry in
//   sum   [31:0]  a + b + cin (low 32 bits)
//   cout          carry out of bit 31
// -----------------------------------------------------------------------------
module hybrid_adder
    import kgp_alu_defs::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int HALF = WIDTH / 2;

    logic [HALF:0] lo;
    logic [HALF:0] hi_c0;
    logic [HALF:0] hi_c1;

    // Lower half ripples; the upper half is computed for both possible
    // carries in parallel and the real carry out of the lower half selects.
    assign lo    = {1'b0, a[HALF-1:0]}     + {1'b0, b[HALF-1:0]}     + {{HALF{1'b0}}, cin};
    assign hi_c0 = {1'b0, a[WIDTH-1:HALF]} + {1'b0, b[WIDTH-1:HALF]};
    assign hi_c1 = {1'b0, a[WIDTH-1:HALF]} + {1'b0, b[WIDTH-1:HALF]} + {{HALF{1'b0}}, 1'b1};

    assign sum  = {(lo[HALF] ? hi_c1[HALF-1:0] : hi_c0[HALF-1:0]), lo[HALF-1:0]};
    assign cout = lo[HALF] ? hi_c1[HALF] : hi_c0[HALF];

endmodule : hybrid_adder

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier : iterative 32x32 unsigned shift-add multiplier, one
// partial-product step per clock through a single hybrid_adder instance.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   in_valid   operands present        in_ready   accepting operands (IDLE)
//   op_a       multiplicand [31:0]     op_b       multiplier [31:0]
//   out_valid  product valid (DONE)    out_ready  consumer accepts product
//   product    op_a*op_b [63:0], zero outside DONE
//   busy       high while stepping (RUN)
// Optional feature: define MUL_ZERO_BYPASS_EN to jump straight from IDLE to
// DONE with a zero product when either operand is zero.
// -----------------------------------------------------------------------------
module seq_multiplier
    import kgp_alu_defs::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    mul_state_t       state;
    mul_state_t       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] q_reg;

    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             last_step;

`ifdef MUL_ZERO_BYPASS_EN
    logic zero_op;
    assign zero_op = (op_a == '0) || (op_b == '0);
`endif

    // Current multiplier LSB decides whether this step adds the multiplicand.
    assign add_b     = q_reg[0] ? m_reg : '0;
    assign last_step = (cnt == CNT_W'(MUL_STEPS - 1));

    hybrid_adder u_step_adder (
        .a    (acc_hi),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            m_reg  <= '0;
            acc_hi <= '0;
            q_reg  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        m_reg  <= op_a;
                        acc_hi <= '0;
                        cnt    <= '0;
`ifdef MUL_ZERO_BYPASS_EN
                        q_reg  <= zero_op ? '0 : op_b;
`else
                        q_reg  <= op_b;
`endif
                    end
                end
                ST_RUN: begin
                    // 65-bit {cout,sum,q} shifted right by one: the carry
                    // becomes the new MSB so no overflow is lost, and the
                    // consumed multiplier bit falls off the bottom.
                    {acc_hi, q_reg} <= {add_cout, add_sum, q_reg[WIDTH-1:1]};
                    cnt             <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // NOTE: next-state defaults are assigned first so no path infers a latch.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
`ifdef MUL_ZERO_BYPASS_EN
                    state_nx = zero_op ? ST_DONE : ST_RUN;
`else
                    state_nx = ST_RUN;
`endif
                end
            end
            ST_RUN:  if (last_step) state_nx = ST_DONE;
            ST_DONE: if (out_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_RUN);
    assign out_valid = (state == ST_DONE);
    assign product   = out_valid ? {acc_hi, q_reg} : '0;

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier : self-checking bench for seq_multiplier. A transaction
// model (accepted product, edges remaining) predicts the handshake outputs and
// the product every cycle; directed cases pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] product;
    logic        busy;

    int total = 0;
    int bad   = 0;

`ifdef MUL_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam int LAT = 32;

    seq_multiplier dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%h want=0x%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    bit          m_have = 1'b0;   // a product has been accepted and not yet taken
    int          m_left = 0;      // edges still needed before the product is ready
    logic [63:0] m_prod = '0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_have = 1'b0;
            m_left = 0;
        end else if (!m_have) begin
            if (in_valid) begin
                m_have = 1'b1;
                m_prod = 64'(op_a) * 64'(op_b);
                m_left = (BYPASS && (op_a == 0 || op_b == 0)) ? 0 : LAT;
            end
        end else if (m_left > 0) begin
            m_left--;
        end else if (out_ready) begin
            m_have = 1'b0;
        end
    end

    // Compare every cycle, on the falling edge, once reset has been applied.
    always @(negedge clk) begin
        if (started) begin
            check("in_ready",  64'(in_ready),  64'(!m_have));
            check("busy",      64'(busy),      64'(m_have && m_left > 0));
            check("out_valid", 64'(out_valid), 64'(m_have && m_left == 0));
            check("product",   product, (m_have && m_left == 0) ? m_prod : 64'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic apply_reset();
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
    endtask

    // Present one operand pair for a single cycle, then count edges until
    // out_valid is seen. Returns the number of edges after the accept edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, output int edges);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #2;
            guard++;
        end
        if (guard >= 200) check("accept_timeout", 64'd1, 64'd0);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        @(posedge clk); #2;           // accept edge
        in_valid = 1'b0;
        edges    = 0;
        @(negedge clk);
        while (!out_valid && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        if (edges >= 100) check("done_timeout", 64'd1, 64'd0);
    endtask

    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp, input int exp_edges);
        int edges;
        out_ready = 1'b1;
        issue(a, b, edges);
        check({name, "_latency"}, 64'(edges), 64'(exp_edges));
        check({name, "_product"}, product, exp);
        @(negedge clk);
        check({name, "_idle_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int edges;
        int guard;

        apply_reset();
        @(negedge clk);
        started = 1'b1;
        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy",      64'(busy),      64'd0);
        check("reset_product",   product,        64'd0);

        // out_ready is already high before DONE in these cases.
        directed("mul_3x5",   32'd3,          32'd5,          64'd15,                 LAT);
        directed("mul_max",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, LAT);
        directed("mul_carry", 32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000, LAT);

        // Stall in DONE: product and in_ready must hold for 10 cycles.
        out_ready = 1'b0;
        issue(32'd7, 32'd9, edges);
        for (int i = 0; i < 10; i++) begin
            check("stall_product",  product,        64'd63);
            check("stall_in_ready", 64'(in_ready),  64'd0);
            @(negedge clk);
        end
        #2 out_ready = 1'b1;
        @(negedge clk);
        check("stall_release_idle", 64'(in_ready), 64'd1);

        // Reset at step 16 discards the operation.
        @(posedge clk); #2;
        in_valid = 1'b1; op_a = 32'h1234; op_b = 32'h5678;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        check("midrun_rst_out_valid", 64'(out_valid), 64'd0);
        check("midrun_rst_in_ready",  64'(in_ready),  64'd1);
        check("midrun_rst_busy",      64'(busy),      64'd0);
        directed("mul_6x7", 32'd6, 32'd7, 64'd42, LAT);

        directed("mul_zero", 32'd0, 32'hDEAD_BEEF, 64'd0, BYPASS ? 0 : LAT);

        // Random operands with random consumer back-pressure.
        for (int t = 0; t < 25; t++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom();
            rb = $urandom();
            if (t % 6 == 0) ra = '0;
            if (t % 7 == 0) rb = 32'hFFFF_FFFF;
            out_ready = 1'b0;
            issue(ra, rb, edges);
            guard = 0;
            while (!in_ready && guard < 300) begin
                #2 out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                guard++;
            end
            if (guard >= 300) check("random_drain_timeout", 64'd1, 64'd0);
        end

        // in_valid held high: back-to-back operations, re-sampled in IDLE.
        out_ready = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            op_a = $urandom();
            op_b = $urandom();
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        repeat (40) @(posedge clk);

        @(negedge clk);
        started = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule : tb_seq_multiplier
